uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate in bit/s.
REQ-003 SHALL have input clk, 1 bit, the system clock; all logic is on the rising edge.
REQ-004 SHALL have input rst, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have input rx, 1 bit, the serial line; it is asynchronous to clk and idles high.
REQ-006 SHALL have output rx_data, 8 bits, the received byte held in the holding register.
REQ-007 SHALL have output rx_valid, 1 bit, high while rx_data holds an unconsumed byte.
REQ-008 SHALL have input rx_ready, 1 bit, the consumer accept signal.
REQ-009 SHALL have output frame_err, 1 bit, a one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have output overrun, 1 bit, a one-cycle pulse when a good byte is dropped because the holding register is full.
REQ-011 SHALL have output rx_busy, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL derive CYCLE = CLK_FREQ/BAUD_RATE and HALF = CYCLE/2 using integer division (868 and 434 at the defaults).
REQ-013 SHALL size the baud counter to $clog2(CYCLE), compare it only against CYCLE-1 and HALF-1, and never let it wrap.
REQ-014 SHALL pass rx through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
REQ-015 SHALL frame as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-016 SHALL have FSM states IDLE, START, DATA, STOP, and SHALL clear the baud counter on every state change.
REQ-017 SHALL move IDLE->START only on a 1->0 transition of rx_s; a line that is merely low does not start a frame.
REQ-018 SHALL, in START, sample rx_s when the counter reaches HALF-1: if 0 go to DATA with bit_cnt=0; if 1 treat it as a false start and go to IDLE with no output.
REQ-019 SHALL, in DATA, sample rx_s into shift[bit_cnt] each time the counter reaches CYCLE-1, incrementing bit_cnt; after bit 7 go to STOP.
REQ-020 SHALL, in STOP, sample rx_s when the counter reaches CYCLE-1 (mid stop bit) and then go to IDLE.
REQ-021 SHALL, if the stop sample is 1 and rx_valid=0, load shift into rx_data and set rx_valid=1 on the next clock edge.
REQ-022 SHALL, if the stop sample is 0, pulse frame_err for one cycle, discard the byte, and leave rx_data and rx_valid unchanged.
REQ-023 SHALL complete a transfer on any clock edge where rx_valid=1 and rx_ready=1, clearing rx_valid on that edge unless REQ-024 applies.
REQ-024 SHALL, if a good byte completes on the same edge as a transfer, load the new byte into rx_data and keep rx_valid=1.
REQ-025 SHALL, if a good byte completes while rx_valid=1 and rx_ready=0, pulse overrun for one cycle, drop the new byte, and keep the old rx_data.
REQ-026 SHALL not let rx_ready affect the FSM; reception continues regardless of backpressure.
REQ-027 SHALL register all outputs, with no combinational path from rx or rx_ready to any output.
REQ-028 SHALL assert rx_valid HALF + 9*CYCLE + 4 clocks (+/-1) after the falling edge on rx.

Reset
REQ-029 SHALL on rst set: state=IDLE, counter=0, bit_cnt=0, shift=0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, rx_busy=0.
REQ-030 SHALL reset the synchronizer flops and edge-detect history to 1, so release of reset with rx low causes no false start.
REQ-031 SHALL, on reset asserted mid-frame, abort immediately; the partial byte is never delivered and no error pulse is produced.

Structure
REQ-032 SHALL place the FSM state typedef (IDLE, START, DATA, STOP) and a function computing CYCLE/HALF from CLK_FREQ and BAUD_RATE in shared package uart_pkg, which the existing transmitter may also adopt.
REQ-033 SHALL implement the 2-flop synchronizer as sub-module uart_sync, with an asynchronous reset and a parameterized reset value (1 here).

Verification
REQ-034 SHALL cover: send 0xA5 at default parameters, rx_ready held 1 -> rx_data=0xA5, a one-cycle rx_valid about 8250 clocks after the start edge, frame_err=0, overrun=0.
REQ-035 SHALL cover: send 0x3C then 0xF0 back-to-back with rx_ready=0 -> rx_data=0x3C, rx_valid=1, one overrun pulse at the second stop sample; raising rx_ready then yields 0x3C once.
REQ-036 SHALL cover: send 0x55 with the stop bit driven 0 -> one frame_err pulse, rx_valid stays 0, then the next frame 0x81 is received correctly.
REQ-037 SHALL cover: a 200-clock low glitch on rx -> return to IDLE at the START mid-sample, with no rx_valid, frame_err, or overrun.
REQ-038 SHALL cover: rst asserted during bit 4 of 0xFF and held low with rx=0 -> all outputs at reset values, no start until rx goes 1->0; then 0x12 is received correctly.
REQ-039 SHALL cover: run the transmitter looped back to uart_rx and send 256 random bytes with random rx_ready -> every byte delivered in order when no overrun is flagged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and bit-timing helper.
package uart_pkg;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t IDLE  = 2'd0;
    localparam uart_state_t START = 2'd1;
    localparam uart_state_t DATA  = 2'd2;
    localparam uart_state_t STOP  = 2'd3;

    typedef struct packed {
        logic [31:0] cycle;
        logic [31:0] half;
    } uart_timing_t;

    // Clocks per bit and per half bit, truncating integer division.
    function automatic uart_timing_t uart_timing(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        uart_timing_t t;
        t.cycle = clk_freq / baud_rate;
        t.half  = t.cycle / 2;
        return t;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset value.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding register, valid/ready handoff and error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam uart_timing_t TIMING = uart_timing(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CYCLE = TIMING.cycle;
    localparam int unsigned HALF  = TIMING.half;
    localparam int unsigned CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;
    localparam logic [CNT_W-1:0] CNT_CYC_END  = CNT_W'(CYCLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);

    logic             w_rx_s;
    logic             w_fall;
    logic             w_half_hit;
    logic             w_cyc_hit;
    logic             w_stop_smp;
    logic             w_good;
    logic             w_bad;
    uart_state_t      w_state_nxt;

    logic             r_rx_prev;
    logic [1:0]       r_warm;
    uart_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_ovr;
    logic             r_busy;

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // The synchronizer reset value flushes out as a fake high-to-low step when rx is held low
    // through reset; edges are only trusted once both sync flops and the history hold real samples.
    assign w_fall     = (r_warm == 2'd3) && r_rx_prev && !w_rx_s;
    assign w_half_hit = (r_cnt == CNT_HALF_END);
    assign w_cyc_hit  = (r_cnt == CNT_CYC_END);
    assign w_stop_smp = (r_state == STOP) && w_cyc_hit;
    assign w_good     = w_stop_smp && w_rx_s;
    assign w_bad      = w_stop_smp && !w_rx_s;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_state_nxt = START;
            START:   if (w_half_hit) w_state_nxt = w_rx_s ? IDLE : DATA;
            DATA:    if (w_cyc_hit && (r_bit_cnt == 3'd7)) w_state_nxt = STOP;
            STOP:    if (w_cyc_hit) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
            r_warm    <= 2'd0;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_busy    <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            // Counter restarts on every state change and at each data-bit sample.
            if ((w_state_nxt != r_state) || ((r_state == DATA) && w_cyc_hit)) begin
                r_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == START) && w_half_hit) begin
                r_bit_cnt <= 3'd0;
            end
            if ((r_state == DATA) && w_cyc_hit) begin
                r_shift[r_bit_cnt] <= w_rx_s;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_bad;
            r_ovr  <= w_good && r_valid && !rx_ready;
            // A completing byte may replace one that is being consumed on this same edge.
            if (w_good && (!r_valid || rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign rx_busy   = r_busy;

endmodule
